// File: rtl/serial_divider.sv
// serial_divider
// ---------------
// Multi-cycle 32-bit integer divider (restoring, one quotient bit per clock)
// for the EX stage DIV/DIVU path. It is a drop-in replacement for the vendor
// divider IP: same port names and the same {quotient, remainder} result
// packing. Instantiate with SIGNED=1 for DIV and SIGNED=0 for DIVU.
//
// Timing: operands are accepted on a clock edge in IDLE when both tvalids
// are high. The result pulse is visible 33 cycles after that accept edge.
// A new operation may be accepted on the very next edge, giving one
// operation every 34 cycles.
//
// Ports:
//   clk                     clock
//   reset                   synchronous active-high reset
//   s_axis_divisor_tvalid   divisor beat valid
//   s_axis_divisor_tready   divisor beat accepted this cycle (high only in IDLE)
//   s_axis_divisor_tdata    32-bit divisor
//   s_axis_dividend_tvalid  dividend beat valid
//   s_axis_dividend_tready  dividend beat accepted (always equals divisor tready)
//   s_axis_dividend_tdata   32-bit dividend
//   m_axis_dout_tvalid      one-cycle result pulse (there is no back-pressure)
//   m_axis_dout_tdata       [63:32] quotient, [31:0] remainder
module serial_divider #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  counter;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvd_shift;
  logic [31:0] dsr_mag;
  logic [31:0] raw_dividend;
  logic        sign_q;
  logic        sign_r;
  logic        div_zero;

  logic        dividend_neg;
  logic        divisor_neg;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        accept;

  // Ready is a pure function of the state, but it is also forced low while
  // reset is held. That way the EX stage never sees a handshake that the
  // reset is about to discard.
  assign s_axis_divisor_tready  = (state == IDLE) && !reset;
  assign s_axis_dividend_tready = s_axis_divisor_tready;

  assign accept = (state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

  // The operands are reduced to magnitudes before the unsigned core runs.
  // Negating 0x80000000 yields 0x80000000 again, which is exactly 2^31 when
  // it is read as unsigned, so the most negative value needs no special case.
  assign dividend_neg = SIGNED && s_axis_dividend_tdata[31];
  assign divisor_neg  = SIGNED && s_axis_divisor_tdata[31];
  assign dividend_mag = dividend_neg ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
  assign divisor_mag  = divisor_neg  ? (32'd0 - s_axis_divisor_tdata)  : s_axis_divisor_tdata;

  // This is one restoring step. The partial remainder takes in the next
  // dividend bit, and the divisor is trial-subtracted from it at 33 bits wide.
  // The borrow out (bit 32) tells whether the subtraction would go negative.
  assign rem_shift = {rem, dvd_shift[31]};
  assign trial     = rem_shift - {1'b0, dsr_mag};

  // This is the main control and datapath register block. Reset discards any
  // operation in flight. Apart from reset, the result valid is a single-cycle
  // pulse, and the result data holds its value until the next DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      counter            <= 5'd0;
      rem                <= 32'd0;
      quo                <= 32'd0;
      dvd_shift          <= 32'd0;
      dsr_mag            <= 32'd0;
      raw_dividend       <= 32'd0;
      sign_q             <= 1'b0;
      sign_r             <= 1'b0;
      div_zero           <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= 64'd0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_shift    <= dividend_mag;
            dsr_mag      <= divisor_mag;
            raw_dividend <= s_axis_dividend_tdata;
            sign_q       <= dividend_neg ^ divisor_neg;
            sign_r       <= dividend_neg;
            div_zero     <= (s_axis_divisor_tdata == 32'd0);
            rem          <= 32'd0;
            quo          <= 32'd0;
            counter      <= 5'd0;
            state        <= CALC;
          end
        end
        CALC: begin
          // When the trial borrows, rem_shift[32] must have been 0, so
          // keeping only the low 32 bits of rem_shift loses nothing.
          rem       <= trial[32] ? rem_shift[31:0] : trial[31:0];
          quo       <= {quo[30:0], ~trial[32]};
          dvd_shift <= {dvd_shift[30:0], 1'b0};
          counter   <= counter + 5'd1;
          if (counter == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          // A zero divisor returns all-ones and the untouched dividend, with
          // no sign correction, in both modes.
          if (div_zero) begin
            m_axis_dout_tdata <= {32'hFFFF_FFFF, raw_dividend};
          end else begin
            m_axis_dout_tdata <= {(sign_q ? (32'd0 - quo) : quo),
                                  (sign_r ? (32'd0 - rem) : rem)};
          end
          m_axis_dout_tvalid <= 1'b1;
          state              <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// tb_serial_divider
// -----------------
// Directed, self-checking bench for serial_divider. A signed (DIV) instance
// and an unsigned (DIVU) instance receive the same operand stream. Every
// vector carries hand-computed results for both modes. The bench checks
// reset values, handshake timing, result latency, sign handling, the corner
// cases, back-to-back throughput and a reset that aborts an operation.
module tb_serial_divider;

  logic        clk;
  logic        reset;
  logic        divisor_valid;
  logic        dividend_valid;
  logic [31:0] divisor;
  logic [31:0] dividend;

  logic        divisor_ready_s;
  logic        dividend_ready_s;
  logic        dout_valid_s;
  logic [63:0] dout_data_s;
  logic        divisor_ready_u;
  logic        dividend_ready_u;
  logic        dout_valid_u;
  logic [63:0] dout_data_u;

  int checks;
  int errors;

  serial_divider #(.SIGNED(1'b1)) dut_signed (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_divisor_tvalid  (divisor_valid),
    .s_axis_divisor_tready  (divisor_ready_s),
    .s_axis_divisor_tdata   (divisor),
    .s_axis_dividend_tvalid (dividend_valid),
    .s_axis_dividend_tready (dividend_ready_s),
    .s_axis_dividend_tdata  (dividend),
    .m_axis_dout_tvalid     (dout_valid_s),
    .m_axis_dout_tdata      (dout_data_s)
  );

  serial_divider #(.SIGNED(1'b0)) dut_unsigned (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_divisor_tvalid  (divisor_valid),
    .s_axis_divisor_tready  (divisor_ready_u),
    .s_axis_divisor_tdata   (divisor),
    .s_axis_dividend_tvalid (dividend_valid),
    .s_axis_dividend_tready (dividend_ready_u),
    .s_axis_dividend_tdata  (dividend),
    .m_axis_dout_tvalid     (dout_valid_u),
    .m_axis_dout_tdata      (dout_data_u)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: stops the run if something hangs
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // The single comparison point: it counts the check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
    end
  endtask

  // All four ready outputs must agree with the single expected level
  function automatic logic [63:0] allReady();
    return {63'd0, divisor_ready_s & dividend_ready_s & divisor_ready_u & dividend_ready_u};
  endfunction

  function automatic logic [63:0] anyReady();
    return {63'd0, divisor_ready_s | dividend_ready_s | divisor_ready_u | dividend_ready_u};
  endfunction

  // Presents one operand pair for a single cycle and then follows the
  // operation through to its result pulse
  task automatic applyStimulus(input string tag, input logic [31:0] dvd, input logic [31:0] dsr,
                               input logic [63:0] exp_s, input logic [63:0] exp_u);
    int lat;
    int busy_bad;
    @(negedge clk);
    dividend       = dvd;
    divisor        = dsr;
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    checkOutput({tag, "_ready_at_accept"}, allReady(), 64'd1);
    @(posedge clk);
    #1;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    dividend       = 32'hDEAD_BEEF;
    divisor        = 32'h0000_0000;
    checkOutput({tag, "_busy_after_accept"}, anyReady(), 64'd0);
    lat      = 0;
    busy_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (dout_valid_s || dout_valid_u) begin
        lat = i;
        break;
      end
      if (anyReady() != 64'd0) busy_bad++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
    checkOutput({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    checkOutput({tag, "_valid_pair"}, {62'd0, dout_valid_s, dout_valid_u}, 64'd3);
    checkOutput({tag, "_signed"}, dout_data_s, exp_s);
    checkOutput({tag, "_unsigned"}, dout_data_u, exp_u);
    checkOutput({tag, "_ready_with_pulse"}, allReady(), 64'd1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse_one_cycle"}, {62'd0, dout_valid_s, dout_valid_u}, 64'd0);
    checkOutput({tag, "_data_hold"}, dout_data_s, exp_s);
  endtask

  // Holds both tvalids high and changes the operands right after each
  // result pulse. The pulses must arrive every 34 cycles, one per operation.
  task automatic backToBack();
    logic [31:0] dvds [3];
    logic [31:0] dsrs [3];
    logic [63:0] exps [3];
    int          times [3];
    int          k;
    dvds[0] = 32'd100;        dsrs[0] = 32'd7; exps[0] = 64'h0000000E_00000002;
    dvds[1] = 32'd9;          dsrs[1] = 32'd3; exps[1] = 64'h00000003_00000000;
    dvds[2] = 32'hFFFF_FFF9;  dsrs[2] = 32'd2; exps[2] = 64'hFFFFFFFD_FFFFFFFF;
    k = 0;
    @(negedge clk);
    dividend       = dvds[0];
    divisor        = dsrs[0];
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk);
      #1;
      if (dout_valid_s) begin
        if (k < 3) begin
          times[k] = c;
          checkOutput($sformatf("b2b_data%0d", k), dout_data_s, exps[k]);
        end
        k++;
        if (k < 3) begin
          dividend = dvds[k];
          divisor  = dsrs[k];
        end else begin
          dividend_valid = 1'b0;
          divisor_valid  = 1'b0;
        end
      end
    end
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    checkOutput("b2b_pulse_count", 64'(k), 64'd3);
    if (k >= 3) begin
      checkOutput("b2b_first", 64'(times[0]), 64'd33);
      checkOutput("b2b_gap1", 64'(times[1] - times[0]), 64'd34);
      checkOutput("b2b_gap2", 64'(times[2] - times[1]), 64'd34);
    end
  endtask

  // Only the divisor side is valid, so no accept is allowed to happen
  task automatic halfValid();
    int not_ready;
    int pulses;
    not_ready = 0;
    pulses    = 0;
    @(negedge clk);
    dividend       = 32'd50;
    divisor        = 32'd5;
    divisor_valid  = 1'b1;
    dividend_valid = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (allReady() != 64'd1) not_ready++;
      if (dout_valid_s || dout_valid_u) pulses++;
    end
    divisor_valid = 1'b0;
    checkOutput("half_valid_ready", 64'(not_ready), 64'd0);
    checkOutput("half_valid_pulses", 64'(pulses), 64'd0);
  endtask

  // Starts 100/7 and resets it mid-flight. No pulse may ever appear, and a
  // fresh operation afterwards must behave normally.
  task automatic resetAbort();
    int pulses;
    pulses = 0;
    @(negedge clk);
    dividend       = 32'd100;
    divisor        = 32'd7;
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    @(posedge clk);
    #1;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("abort_ready_in_reset", anyReady(), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("abort_valid_in_reset", {62'd0, dout_valid_s, dout_valid_u}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_ready_after_release", allReady(), 64'd1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (dout_valid_s || dout_valid_u) pulses++;
    end
    checkOutput("abort_no_pulse", 64'(pulses), 64'd0);
    checkOutput("abort_data_cleared", dout_data_s, 64'd0);
    applyStimulus("after_abort_9_3", 32'd9, 32'd3, 64'h00000003_00000000, 64'h00000003_00000000);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    divisor_valid  = 1'b0;
    dividend_valid = 1'b0;
    divisor        = 32'd0;
    dividend       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", anyReady(), 64'd0);
    checkOutput("reset_valid", {62'd0, dout_valid_s, dout_valid_u}, 64'd0);
    checkOutput("reset_data", dout_data_s | dout_data_u, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", allReady(), 64'd1);

    $display("[TB] directed vectors");
    applyStimulus("100_div_7",   32'd100,         32'd7,
                  64'h0000000E_00000002, 64'h0000000E_00000002);
    applyStimulus("m7_div_2",    32'hFFFF_FFF9,   32'd2,
                  64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001);
    applyStimulus("7_div_m2",    32'd7,           32'hFFFF_FFFE,
                  64'hFFFFFFFD_00000001, 64'h00000000_00000007);
    applyStimulus("ffff_div_16", 32'hFFFF_FFFF,   32'h0000_0010,
                  64'h00000000_FFFFFFFF, 64'h0FFFFFFF_0000000F);
    applyStimulus("m100_div_7",  32'hFFFF_FF9C,   32'd7,
                  64'hFFFFFFF2_FFFFFFFE, 64'h24924916_00000002);
    applyStimulus("div_zero",    32'h1234_5678,   32'd0,
                  64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678);
    applyStimulus("overflow",    32'h8000_0000,   32'hFFFF_FFFF,
                  64'h80000000_00000000, 64'h00000000_80000000);

    $display("[TB] back-to-back accepts");
    backToBack();
    repeat (2) @(posedge clk);

    $display("[TB] single tvalid");
    halfValid();

    $display("[TB] reset during operation");
    resetAbort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
